// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command codes, response bytes and FSM states shared by the UART command sequencer
package uart_cmd_pkg;
    localparam logic [7:0] CMD_SEND        = 8'h00;
    localparam logic [7:0] CMD_WR_ALL      = 8'h01;
    localparam logic [7:0] CMD_STOP        = 8'h02;
    localparam logic [7:0] CMD_WR_ONE_BASE = 8'h10;
    localparam logic [7:0] ACK_BYTE        = 8'hAA;
    localparam logic [7:0] NAK_BYTE        = 8'hEE;
    typedef enum logic [2:0] {IDLE, DECODE, COLLECT, COMMIT, RESPOND} state_e;
endpackage

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: MSB-first byte-to-word shift register with byte counter
module uart_word_assembler #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_in_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_done_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
    logic [CW-1:0] cnt_q;
    logic [DATA_W-1:0] word_q;
    assign word_o = word_q;
    assign word_done_o = byte_valid_i && cnt_q == CW'(BYTES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            if (byte_valid_i) word_q <= (word_q << 8) | DATA_W'(byte_in_i);
            cnt_q <= (clear_i || word_done_o) ? '0 : byte_valid_i ? cnt_q + CW'(1) : cnt_q;
        end
    end
endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: decodes UART command bytes, assembles register words, reports errors and ACK/NAK
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int NUM_REGS       = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ACK_EN         = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_ready,
    input  logic                tx_busy,
    output logic                en_send,
    output logic                send_active,
    output logic [NUM_REGS-1:0] reg_wr_en,
    output logic [DATA_W-1:0]   reg_wr_data,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                cmd_error,
    output logic                rx_overrun
);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    state_e state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [IW-1:0] idx_q, idx_d;
    logic all_q, all_d, nak_q, nak_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [DATA_W-1:0] word;
    logic word_done, timeout, is_wr_one, is_bad, last_reg;
    logic en_send_d, send_active_d, tx_start_d, cmd_error_d, rx_overrun_d;
    logic [NUM_REGS-1:0] reg_wr_en_d;
    logic [DATA_W-1:0] reg_wr_data_d;
    logic [7:0] tx_data_d;
    uart_word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (state_q != COLLECT),
        .byte_valid_i(state_q == COLLECT && rx_ready),
        .byte_in_i   (rx_data),
        .word_o      (word),
        .word_done_o (word_done)
    );
    assign is_wr_one = cmd_q[7:4] == CMD_WR_ONE_BASE[7:4] && int'(cmd_q[3:0]) < NUM_REGS;
    assign is_bad = !(cmd_q == CMD_SEND || cmd_q == CMD_STOP || cmd_q == CMD_WR_ALL || is_wr_one);
    assign last_reg = idx_q == IW'(NUM_REGS - 1);
    // the gap timer fires on the TIMEOUT_CYCLES-th consecutive byte-less cycle in COLLECT
    assign timeout = TIMEOUT_CYCLES != 0 && state_q == COLLECT && !rx_ready && tmr_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            idx_q       <= '0;
            all_q       <= 1'b0;
            nak_q       <= 1'b0;
            tmr_q       <= '0;
            en_send     <= 1'b0;
            send_active <= 1'b0;
            reg_wr_en   <= '0;
            reg_wr_data <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            cmd_error   <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            all_q       <= all_d;
            nak_q       <= nak_d;
            tmr_q       <= tmr_d;
            en_send     <= en_send_d;
            send_active <= send_active_d;
            reg_wr_en   <= reg_wr_en_d;
            reg_wr_data <= reg_wr_data_d;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            cmd_error   <= cmd_error_d;
            rx_overrun  <= rx_overrun_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        all_d   = all_q;
        nak_d   = nak_q;
        tmr_d   = (state_q != COLLECT || rx_ready) ? '0 : tmr_q == TW'(TIMEOUT_CYCLES) ? tmr_q : tmr_q + TW'(1);
        case (state_q)
            IDLE: if (rx_ready) begin
                cmd_d   = rx_data;
                state_d = DECODE;
            end
            DECODE: begin
                nak_d   = is_bad;
                state_d = RESPOND;
                if (cmd_q == CMD_WR_ALL) begin
                    idx_d   = '0;
                    all_d   = 1'b1;
                    state_d = COLLECT;
                end else if (is_wr_one) begin
                    idx_d   = IW'(cmd_q[3:0]);
                    all_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            COLLECT: if (word_done) state_d = COMMIT;
                else if (timeout) begin
                    nak_d   = 1'b1;
                    state_d = RESPOND;
                end
            COMMIT: if (all_q && !last_reg) begin
                idx_d   = idx_q + IW'(1);
                state_d = COLLECT;
            end else state_d = RESPOND;
            RESPOND: if (ACK_EN == 0 || !tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        en_send_d     = state_q == DECODE && cmd_q == CMD_SEND;
        send_active_d = en_send_d ? 1'b1 : (state_q == DECODE && cmd_q == CMD_STOP) ? 1'b0 : send_active;
        reg_wr_en_d   = state_q == COMMIT ? NUM_REGS'(1) << idx_q : '0;
        reg_wr_data_d = state_q == COMMIT ? word : reg_wr_data;
        tx_start_d    = ACK_EN != 0 && state_q == RESPOND && !tx_busy;
        tx_data_d     = tx_start_d ? (nak_q ? NAK_BYTE : ACK_BYTE) : tx_data;
        cmd_error_d   = (state_q == DECODE && is_bad) || timeout;
        rx_overrun_d  = rx_ready && (state_q == DECODE || state_q == COMMIT || state_q == RESPOND);
    end
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: randomized scoreboard bench for the UART command sequencer
module tb_uart_cmd_sequencer;
    localparam int DW = 16;
    localparam int NR = 2;
    localparam int TO = 1000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic rx_ready = 1'b0;
    logic tx_busy = 1'b0;
    logic en_send, send_active, tx_start, cmd_error, rx_overrun;
    logic [NR-1:0] reg_wr_en;
    logic [DW-1:0] reg_wr_data;
    logic [7:0] tx_data;
    int n_cmp = 0;
    int n_bad = 0;
    int ovr_seen = 0;
    int ovr_exp = 0;
    logic prev_busy = 1'b0;
    logic exp_sa = 1'b0;
    logic [27:0] exp_q[$];
    always #5 clk = ~clk;
    uart_cmd_sequencer #(.DATA_W(DW), .NUM_REGS(NR), .TIMEOUT_CYCLES(TO), .ACK_EN(1)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready), .tx_busy(tx_busy),
        .en_send(en_send), .send_active(send_active), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .tx_start(tx_start), .tx_data(tx_data), .cmd_error(cmd_error), .rx_overrun(rx_overrun)
    );
    function automatic logic [27:0] tok(input logic [3:0] k, input logic [7:0] a, input logic [15:0] b);
        return {k, a, b};
    endfunction
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic pop(input string nm, input logic [27:0] got);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got unexpected event %h expected none", nm, got);
        end else check(nm, 32'(got), 32'(exp_q.pop_front()));
    endtask
    // event kinds: 1 error, 2 send start, 3 register write, 4 response byte
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_error) pop("cmd_error", tok(4'd1, 8'd0, 16'd0));
            if (en_send) pop("en_send", tok(4'd2, 8'd0, 16'(send_active)));
            if (reg_wr_en != 0) pop("reg_write", tok(4'd3, 8'(reg_wr_en), reg_wr_data));
            if (tx_start) begin
                pop("tx_byte", tok(4'd4, tx_data, 16'(send_active)));
                check("tx_while_busy", 32'(prev_busy), 32'd0);
            end
            if (rx_overrun) ovr_seen++;
        end
        prev_busy = tx_busy;
    end
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic put_byte(input logic [7:0] b);
        rx_data = b;
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
    endtask
    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            idle(1);
            w++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask
    function automatic logic [30:0] outs();
        return {en_send, send_active, reg_wr_en, reg_wr_data, tx_start, tx_data, cmd_error, rx_overrun};
    endfunction
    // expected responses follow the command table: what gets written, and whether ACK or NAK comes back
    task automatic do_cmd(input logic [7:0] c, input logic [15:0] w0, input logic [15:0] w1, input bit busy);
        logic [15:0] wd[NR];
        int first = 0;
        int cnt = 0;
        wd[0] = w0;
        wd[1] = w1;
        if (c == 8'h01) cnt = NR;
        else if (c >= 8'h10 && c < 8'h10 + NR) begin
            first = int'(c) - 16;
            cnt = 1;
        end
        if (c == 8'h00) begin
            exp_sa = 1'b1;
            exp_q.push_back(tok(4'd2, 8'd0, 16'd1));
            exp_q.push_back(tok(4'd4, 8'hAA, 16'd1));
        end else if (c == 8'h02) begin
            exp_sa = 1'b0;
            exp_q.push_back(tok(4'd4, 8'hAA, 16'd0));
        end else if (cnt > 0) begin
            for (int r = first; r < first + cnt; r++) exp_q.push_back(tok(4'd3, 8'(1 << r), wd[r]));
            exp_q.push_back(tok(4'd4, 8'hAA, 16'(exp_sa)));
        end else begin
            exp_q.push_back(tok(4'd1, 8'd0, 16'd0));
            exp_q.push_back(tok(4'd4, 8'hEE, 16'(exp_sa)));
        end
        put_byte(c);
        idle(1 + $urandom % 4);
        for (int r = first; r < first + cnt; r++) begin
            put_byte(wd[r][15:8]);
            idle(1 + $urandom % 4);
            put_byte(wd[r][7:0]);
            idle(1 + $urandom % 4);
        end
        if (busy) begin
            tx_busy = 1'b1;
            idle($urandom % 20);
            tx_busy = 1'b0;
        end
        drain();
    endtask
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int w;
        logic [7:0] pick[6];
        idle(3);
        check("reset_outputs", 32'(outs()), 32'd0);
        reset = 1'b0;
        idle(2);
        check("idle_outputs", 32'(outs()), 32'd0);
        do_cmd(8'h00, 16'h0, 16'h0, 1'b0);
        do_cmd(8'h02, 16'h0, 16'h0, 1'b0);
        do_cmd(8'h01, 16'h1234, 16'hABCD, 1'b0);
        do_cmd(8'h11, 16'h0, 16'h5566, 1'b0);
        do_cmd(8'h7F, 16'h0, 16'h0, 1'b0);
        do_cmd(8'h00, 16'h0, 16'h0, 1'b0);
        do_cmd(8'h00, 16'h0, 16'h0, 1'b0);
        // timeout after one committed register in write-all mode
        exp_q.push_back(tok(4'd3, 8'd1, 16'h1234));
        exp_q.push_back(tok(4'd1, 8'd0, 16'd0));
        exp_q.push_back(tok(4'd4, 8'hEE, 16'(exp_sa)));
        put_byte(8'h01);
        idle(2);
        put_byte(8'h12);
        idle(1);
        put_byte(8'h34);
        idle(2);
        put_byte(8'hAB);
        w = 0;
        while (!cmd_error && w < 3 * TO) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (w < TO || w > TO + 2) begin
            n_bad++;
            $display("FAIL timeout_gap: got %0d cycles expected %0d..%0d", w, TO, TO + 2);
        end
        idle(1);
        drain();
        // response held back by a busy transmitter, with a byte arriving meanwhile
        tx_busy = 1'b1;
        exp_sa = 1'b1;
        exp_q.push_back(tok(4'd2, 8'd0, 16'd1));
        exp_q.push_back(tok(4'd4, 8'hAA, 16'd1));
        put_byte(8'h00);
        idle(3);
        put_byte(8'h99);
        ovr_exp++;
        idle(45);
        check("ack_held", 32'(exp_q.size()), 32'd1);
        tx_busy = 1'b0;
        drain();
        put_byte(8'h11);
        idle(2);
        put_byte(8'h55);
        idle(1);
        reset = 1'b1;
        idle(1);
        check("reset_mid_collect", 32'(outs()), 32'd0);
        reset = 1'b0;
        exp_sa = 1'b0;
        idle(30);
        check("no_write_after_reset", 32'(exp_q.size()), 32'd0);
        pick[0] = 8'h00;
        pick[1] = 8'h01;
        pick[2] = 8'h02;
        pick[3] = 8'h10;
        pick[4] = 8'h11;
        for (int i = 0; i < 40; i++) begin
            pick[5] = 8'($urandom);
            do_cmd(pick[$urandom % 6], 16'($urandom), 16'($urandom), 1'($urandom));
        end
        check("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
Parametrised UART command controller, successor of the fixed two-register command FSM. It decodes command bytes arriving from the UART RX and starts or stops the SendData streaming machine. It assembles multi-byte threshold words for NUM_REGS registers, either all in sequence or one at a time. It adds a byte-gap timeout, error reporting, and an optional ACK/NAK byte to the UART TX.

Parameters:
DATA_W, 16, threshold register width in bits; multiple of 8, min 8; BYTES = DATA_W/8
NUM_REGS, 2, number of threshold registers; 1..16
TIMEOUT_CYCLES, 100000, max clk cycles between payload bytes; 0 disables the timeout
ACK_EN, 1, 1 = emit a response byte after every command; 0 = no TX activity

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
rx_data  in  8  received UART byte, valid when rx_ready
rx_ready  in  1  one-cycle strobe per received byte
tx_busy  in  1  UART TX busy; tx_start is legal only when low
en_send  out  1  one-cycle pulse: start SendData streaming
send_active  out  1  level: streaming enabled (set by SEND, cleared by STOP)
reg_wr_en  out  NUM_REGS  one-hot one-cycle write strobe per register
reg_wr_data  out  DATA_W  assembled word; valid while reg_wr_en != 0, held otherwise
tx_start  out  1  one-cycle pulse: send tx_data
tx_data  out  8  response byte; held until the next tx_start
cmd_error  out  1  one-cycle pulse: unknown code or timeout
rx_overrun  out  1  one-cycle pulse: byte arrived in a state that cannot accept it (byte dropped)

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Synchronous reset mid-command aborts it: no write, no response.
- All outputs are registered. N denotes the cycle in which rx_ready is high.
- Command codes: CMD_SEND=0x00, CMD_WR_ALL=0x01, CMD_STOP=0x02, CMD_WR_ONE=0x10+k for k<NUM_REGS. Any other byte is invalid.
- States: IDLE, DECODE, COLLECT, COMMIT, RESPOND.
- IDLE: on rx_ready, latch rx_data and go to DECODE.
- DECODE (one cycle):
  - SEND: en_send=1 and send_active=1 in cycle N+2; then RESPOND(ACK).
  - STOP: send_active=0 from N+2; then RESPOND(ACK).
  - WR_ALL: reg_idx=0, all_mode=1, byte_cnt=0; then COLLECT.
  - WR_ONE: reg_idx=k, all_mode=0; then COLLECT.
  - Invalid: cmd_error pulse at N+2; then RESPOND(NAK). No hang on invalid codes.
- COLLECT:
  - On rx_ready: shift the byte in MSB-first (first byte = bits DATA_W-1..DATA_W-8), byte_cnt++, clear the gap timer.
  - After byte BYTES-1: go to COMMIT.
  - With no byte, gap timer increments. At TIMEOUT_CYCLES: cmd_error pulse, then RESPOND(NAK). The partial word is discarded; registers already committed in WR_ALL stay written.
- COMMIT (one cycle): reg_wr_en[reg_idx]=1 and reg_wr_data=word at N+2 relative to the final byte.
  - all_mode and reg_idx<NUM_REGS-1: reg_idx++, byte_cnt=0, then COLLECT.
  - Otherwise: RESPOND(ACK).
- RESPOND:
  - ACK_EN=0: go to IDLE next cycle.
  - ACK_EN=1: wait while tx_busy; when low, tx_start=1 with tx_data=0xAA (ACK) or 0xEE (NAK) for one cycle, then IDLE.
  - tx_busy high forever: stay in RESPOND. No timeout here.
- rx_ready in DECODE, COMMIT or RESPOND: byte dropped, rx_overrun pulse. The FSM path is unchanged.
- SEND while send_active=1: en_send pulses again (restart) and the command is ACKed.
- reg_wr_en is never multi-hot; at most one register is written per cycle.
- Timer width is $clog2(TIMEOUT_CYCLES+1) and saturates, so it cannot wrap.

Decomposition:
- Package uart_cmd_pkg: command code constants (CMD_SEND, CMD_WR_ALL, CMD_STOP, CMD_WR_ONE_BASE), ACK_BYTE=0xAA, NAK_BYTE=0xEE, state enum.
- Sub-module uart_word_assembler: DATA_W shift register plus byte counter, with inputs clear/byte_valid/byte_in and outputs word/word_done. The top FSM owns the timer, decode and TX response.

Test Plan:
1. Reset, then byte 0x00, tx_busy=0 -> en_send pulse at N+2, send_active=1, tx_start with tx_data=0xAA; then byte 0x02 -> send_active=0 and a second ACK.
2. Bytes 0x01,0x12,0x34,0xAB,0xCD -> reg_wr_en=01 with data 0x1234, then reg_wr_en=10 with data 0xABCD; exactly one ACK.
3. Bytes 0x11,0x55,0x66 -> only reg_wr_en[1] with 0x5566; reg 0 is never strobed; ACK.
4. Byte 0x7F -> cmd_error pulse, tx_data=0xEE; FSM back in IDLE; a following 0x00 is accepted normally.
5. TIMEOUT_CYCLES=1000; bytes 0x01,0x12,0x34,0xAB, then silence -> reg0 written with 0x1234; cmd_error at gap 1000; reg1 not written; NAK.
6. tx_busy held high 50 cycles after 0x00, byte injected during RESPOND, reset asserted mid-COLLECT on a later command -> ACK sent only after tx_busy falls; rx_overrun pulse; reset leaves all outputs at 0 and no write.
